// File: rtl/interval_timer_if.sv
// Signal bundle between the light-sequencing FSM (master) and interval_timer (slave).
// Carries reprogramming inputs, interval start requests and timer status.
interface interval_timer_if;
  logic       Reprogram;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic       Start_Timer;
  logic [1:0] Interval_Select;
  logic       Expired;
  logic       Busy;
  logic [3:0] Seconds_Left;
  logic       Tick_1Hz;

  modport slave (
    input  Reprogram, Time_Parameter_Selector, Time_Value, Start_Timer, Interval_Select,
    output Expired, Busy, Seconds_Left, Tick_1Hz
  );

  modport master (
    output Reprogram, Time_Parameter_Selector, Time_Value, Start_Timer, Interval_Select,
    input  Expired, Busy, Seconds_Left, Tick_1Hz
  );
endinterface

// File: rtl/interval_timer.sv
// Interval store and seconds timer: holds base/extended/yellow lengths, accepts
// reprogramming from an asynchronous pushbutton and counts the selected interval.
module interval_timer #(
  parameter int unsigned CLKS_PER_SEC = 100,
  parameter logic [3:0]  DEFAULT_BASE = 4'd6,
  parameter logic [3:0]  DEFAULT_EXT  = 4'd3,
  parameter logic [3:0]  DEFAULT_YEL  = 4'd2
) (
  input  logic            clk,
  input  logic            Reset,
  interval_timer_if.slave bus
);
  localparam int unsigned   PW        = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_SEC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    secs_q, secs_d;
  logic          expired_q, expired_d;
  logic [3:0]    base_q, base_d, ext_q, ext_d, yel_q, yel_d;
  logic [2:0]    sync_q;
  logic          rp_edge, tick, start_ok;
  logic [3:0]    wr_val, sel_val;

  // sync_q[1:0] is the synchroniser; sync_q[2] holds the previous synchronised level
  assign rp_edge  = sync_q[1] & ~sync_q[2];
  assign tick     = (presc_q == PRESC_MAX);
  assign start_ok = bus.Start_Timer && (bus.Interval_Select != 2'b11) && !rp_edge;
  assign wr_val   = (bus.Time_Value == 4'd0) ? 4'd1 : bus.Time_Value;

  always_comb begin
    case (bus.Interval_Select)
      2'b00:   sel_val = base_q;
      2'b01:   sel_val = ext_q;
      default: sel_val = yel_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    secs_d    = secs_q;
    expired_d = 1'b0;
    base_d    = base_q;
    ext_d     = ext_q;
    yel_d     = yel_q;

    if (rp_edge) begin
      case (bus.Time_Parameter_Selector)
        2'b00:   base_d = wr_val;
        2'b01:   ext_d  = wr_val;
        2'b10:   yel_d  = wr_val;
        default: ;
      endcase
      state_d = IDLE;
      secs_d  = 4'd0;
      presc_d = '0;
    end else begin
      if (state_q == RUN && tick) begin
        if (secs_q == 4'd1) begin
          expired_d = 1'b1;
          state_d   = IDLE;
          secs_d    = 4'd0;
        end else begin
          secs_d = secs_q - 4'd1;
        end
      end
      // A start overrides the countdown above; a final tick still reports Expired
      if (start_ok) begin
        state_d = RUN;
        secs_d  = sel_val;
        presc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      secs_q    <= 4'd0;
      expired_q <= 1'b0;
      base_q    <= DEFAULT_BASE;
      ext_q     <= DEFAULT_EXT;
      yel_q     <= DEFAULT_YEL;
      sync_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      secs_q    <= secs_d;
      expired_q <= expired_d;
      base_q    <= base_d;
      ext_q     <= ext_d;
      yel_q     <= yel_d;
      sync_q    <= {sync_q[1:0], bus.Reprogram};
    end
  end

  assign bus.Expired      = expired_q;
  assign bus.Busy         = (state_q == RUN);
  assign bus.Seconds_Left = secs_q;
  assign bus.Tick_1Hz     = tick;
endmodule
